// File: rtl/bitop_result_fifo_if.sv
// Handshake bundle between the AND/OR select stage, the result FIFO and the
// downstream consumer. The slave modport is the FIFO's view; the master
// modport is the environment that drives results in and takes them out.
interface bitop_result_fifo_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_op;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_op;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_data, out_op
  );

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_op
  );
endinterface

// File: rtl/bitop_result_fifo.sv
// Result FIFO behind the AND/OR select block. Buffers the result word with
// its op tag (1=AND, 0=OR) and keeps saturating per-op accept counters.
// Optional feature macro: BITOP_FIFO_ZERO_FLAG_EN adds out_zero (head entry
// is zero) and zero_cnt (saturating count of accepted all-zero results).
module bitop_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  bitop_result_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count,
`ifdef BITOP_FIFO_ZERO_FLAG_EN
  output logic                     out_zero,
  output logic [CNT_W-1:0]         zero_cnt,
`endif
  output logic [CNT_W-1:0]         and_cnt,
  output logic [CNT_W-1:0]         or_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic             op_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic [CNT_W-1:0] and_cnt_reg;
  logic [CNT_W-1:0] or_cnt_reg;

  logic push;
  logic pop;

  // Ready/valid come only from the registered occupancy, so a pop never
  // frees a slot for a push in the same cycle.
  assign bus.in_ready  = (count_reg != FULL_COUNT);
  assign bus.out_valid = (count_reg != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Head entry, forced to zero while empty so stale storage never leaks out.
  assign bus.out_data = bus.out_valid ? data_mem[rd_ptr_reg] : '0;
  assign bus.out_op   = bus.out_valid ? op_mem[rd_ptr_reg]   : 1'b0;

  assign count   = count_reg;
  assign and_cnt = and_cnt_reg;
  assign or_cnt  = or_cnt_reg;

  // Storage entries: each slot captures data and tag when the write pointer
  // addresses it; contents are not reset because occupancy gates the output.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst && push && (wr_ptr_reg == PTR_W'(gi))) begin
        data_mem[gi] <= bus.in_data;
        op_mem[gi]   <= bus.in_op;
      end
    end
  end

  // Occupancy update: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Per-op accept counters, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_cnt_reg <= '0;
      or_cnt_reg  <= '0;
    end else if (push) begin
      if (bus.in_op && (and_cnt_reg != '1))
        and_cnt_reg <= and_cnt_reg + 1'b1;
      if (!bus.in_op && (or_cnt_reg != '1))
        or_cnt_reg <= or_cnt_reg + 1'b1;
    end
  end

`ifdef BITOP_FIFO_ZERO_FLAG_EN
  logic [CNT_W-1:0] zero_cnt_reg;

  assign out_zero = bus.out_valid & (bus.out_data == '0);
  assign zero_cnt = zero_cnt_reg;

  // Saturating count of accepted results that were all zero.
  always_ff @(posedge clk) begin
    if (rst)
      zero_cnt_reg <= '0;
    else if (push && (bus.in_data == '0) && (zero_cnt_reg != '1))
      zero_cnt_reg <= zero_cnt_reg + 1'b1;
  end
`endif

endmodule

// File: doc/bitop_result_fifo.md
Name: bitop_result_fifo

Overview:
- Downstream stage of the AND/OR select block; buffers its 8-bit result together with the op tag (x: 1=AND, 0=OR).
- Decouples the combinational bitwise unit from a consumer that can stall, using valid/ready handshakes on both sides.
- Also keeps saturating per-op accept counters for debug/perf visibility.

Parameters:
- WIDTH, 8, data width of the result word.
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_W, 16, width of each per-op accept counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_data  input  WIDTH  upstream result (AND or OR of a, b).
- in_op  input  1  op tag: 1=AND, 0=OR (the upstream x).
- in_ready  output  1  FIFO can accept this cycle.
- out_valid  output  1  head entry valid.
- out_data  output  WIDTH  head entry data.
- out_op  output  1  head entry op tag.
- out_ready  input  1  consumer accepts head this cycle.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- and_cnt  output  CNT_W  number of accepted entries with in_op=1, saturating.
- or_cnt  output  CNT_W  number of accepted entries with in_op=0, saturating.

Behaviour:
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on the registered count; there is no combinational path from out_ready to in_ready. When full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0). out_data/out_op come from the storage entry at rd_ptr. They are forced to 0 when empty.
- No bypass: an entry pushed in cycle N is first visible at out_valid in cycle N+1. Minimum latency is 1 cycle.
- Write pointer and read pointer are clog2(DEPTH) bits each and wrap modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, and both pointers advance.
- Order is strict FIFO. Data and op tag travel together.
- out_data and out_op hold stable while out_valid=1 and out_ready=0.
- and_cnt/or_cnt increment on push according to in_op. They saturate at all-ones and never wrap.
- Reset (any cycle, including mid-traffic):
  - count=0, pointers=0, out_valid=0, out_data=0, out_op=0, in_ready=1, and_cnt=0, or_cnt=0.
  - Stored contents are discarded.
  - A push or pop presented during the reset cycle is ignored.
- in_data/in_op are don't-care when in_valid=0.

Optional Feature:
- Macro: BITOP_FIFO_ZERO_FLAG_EN.
- When defined:
  - Adds output out_zero (1 bit) = out_valid & (out_data == 0).
  - Adds output zero_cnt (CNT_W), a saturating count of accepted entries whose in_data == 0. Reset value is 0.
- When undefined: neither port exists and there is no extra logic.

Test Plan:
- Reset, then push 8'hA5 op=1 in cycle 1 with out_ready=0 -> cycle 2: out_valid=1, out_data=A5, out_op=1, count=1, and_cnt=1, or_cnt=0.
- Push 0x01,0x02,0x03,0x04 (op=0) with out_ready=0 -> count=4, in_ready=0. A 5th push of 0x05 is refused. Then out_ready=1 -> pops 01,02,03,04 in order, count returns to 0, or_cnt=4.
- Full FIFO, in_valid=1 and out_ready=1 in the same cycle -> pop occurs, push refused, count=3. Next cycle the push is accepted and count=4.
- Steady stream with in_valid=1 and out_ready=1 for 20 cycles, data 0..19 -> after first fill, count stays 1 and outputs appear in order. Pointers wrap past DEPTH with no loss or duplication.
- Preload and_cnt near all-ones (CNT_W=4 build, 17 AND pushes) -> and_cnt stops at 4'hF.
- Assert rst while count=3 -> next cycle count=0, out_valid=0, out_data=0, counters=0. With BITOP_FIFO_ZERO_FLAG_EN, push 0x00 -> out_zero=1 and zero_cnt=1.
